// File: rtl/uart_transmitter_fifo.sv
// Snapshot-and-send byte buffer feeding the UART TX core.
// Optional CR/LF tail: define UART_TX_FIFO_CRLF_EN.
module uart_transmitter_fifo #(
  parameter int BUFFER_SIZE = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          iCLR,
  input  logic                          iSTART,
  input  logic [$clog2(BUFFER_SIZE):0]  iLEN,
  input  logic [8*BUFFER_SIZE-1:0]      iDATA,
  input  logic                          iTX_BUSY,
  output logic                          oDE,
  output logic [7:0]                    oDATA,
  output logic                          oBUSY,
  output logic                          oDONE
);

  localparam int IW = $clog2(BUFFER_SIZE) + 1;
  localparam int SW = IW - 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } state_t;

  state_t state_q, state_n;

  logic [BUFFER_SIZE-1:0][7:0] snap_q;
  logic [BUFFER_SIZE-1:0][7:0] src_snap;
  logic [IW-1:0] len_q, idx_q, idx_n;
  logic [IW-1:0] len_in, src_idx, src_len;
  logic [1:0]    tail_q, tail_n;
  logic [7:0]    data_n, src_byte;
  logic          accept, take, pay_ok;

  assign len_in = (iLEN > IW'(BUFFER_SIZE)) ?
                  IW'(BUFFER_SIZE) : iLEN;

  // In IDLE the candidate byte comes straight from the inputs
  // so the first strobe can follow the start edge directly.
  assign src_snap = (state_q == IDLE) ? iDATA : snap_q;
  assign src_len  = (state_q == IDLE) ? len_in : len_q;
  assign src_idx  = (state_q == IDLE) ? '0 : idx_q + IW'(1);
  assign src_byte = src_snap[src_idx[SW-1:0]];
  assign pay_ok   = (src_idx < src_len) &&
                    (src_byte != 8'h00);

  // Next-state, next-byte and abort handling.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    tail_n  = tail_q;
    data_n  = oDATA;
    accept  = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iSTART) begin
          accept = 1'b1;
          idx_n  = '0;
          tail_n = 2'd0;
          take   = 1'b1;
        end
      end
      SEND: state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (iTX_BUSY) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!iTX_BUSY) begin
          unique case (tail_q)
            2'd0: begin
              idx_n = idx_q + IW'(1);
              take  = 1'b1;
            end
            2'd1: begin
              tail_n  = 2'd2;
              state_n = SEND;
              data_n  = 8'h0A;
            end
            default: state_n = DONE;
          endcase
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      if (pay_ok) begin
        state_n = SEND;
        data_n  = src_byte;
      end else begin
`ifdef UART_TX_FIFO_CRLF_EN
        tail_n  = 2'd1;
        state_n = SEND;
        data_n  = 8'h0D;
`else
        state_n = DONE;
`endif
      end
    end
    if (iCLR) begin
      state_n = IDLE;
      idx_n   = '0;
      tail_n  = 2'd0;
      data_n  = 8'h00;
      accept  = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tail_q  <= 2'd0;
      oDE     <= 1'b0;
      oDATA   <= 8'h00;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      tail_q  <= tail_n;
      oDE     <= (state_n == SEND);
      oDATA   <= data_n;
      oBUSY   <= (state_n != IDLE);
      oDONE   <= (state_n == DONE);
    end
  end

  // Snapshot of buffer and clamped length on acceptance.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_q <= '0;
      len_q  <= '0;
    end else if (iCLR) begin
      snap_q <= '0;
      len_q  <= '0;
    end else if (accept) begin
      snap_q <= iDATA;
      len_q  <= len_in;
    end
  end

endmodule
